fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction fetch stage directly upstream of the decoder. Holds the PC, issues single-word reads to the synchronous instruction memory, captures the returned word, and presents it to the decoder with a valid/ready handshake. Accepts PC redirects (branch/jump/trap) from control and flags misaligned targets. Outputs a byte address; the top-level drops bits [1:0] to form the memory word address.

Parameters:
ADDR_W, 32, width of byte address / PC
RESET_PC, 32'h0000_0000, PC loaded on reset

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  synchronous active-high reset
mem_rd_en_o  out  1  memory read strobe, one cycle per request
mem_addr_o  out  ADDR_W  byte address of the request (= pc_o)
mem_data_i  in  32  read data, valid the cycle after mem_rd_en_o
instr_o  out  32  captured instruction to the decoder
pc_o  out  ADDR_W  PC of instr_o / current request
valid_o  out  1  instr_o/pc_o valid for the decoder
ready_i  in  1  decoder accepts instr_o this cycle
redirect_i  in  1  control requests PC change
redirect_pc_i  in  ADDR_W  new PC target
misaligned_o  out  1  redirect target had [1:0] != 0

Behaviour:
- Reset (rst_i=1 at an edge): state=REQ, pc=RESET_PC, instr=INSTR_NOP (32'h0000_0013), valid_o=0, misaligned_o=0. mem_rd_en_o is forced 0 while rst_i=1. Reset mid-fetch drops any in-flight response.
- FSM states: REQ, WAIT, HOLD, FAULT.
- REQ: mem_rd_en_o=1, mem_addr_o=pc. Next: WAIT.
- WAIT: mem_data_i is valid. Register it into instr. Next: HOLD.
- HOLD: valid_o=1. instr_o and pc_o are stable until accepted. If ready_i=1: pc<=pc+4 and next state is REQ. Otherwise stay in HOLD.
- Throughput: 3 cycles per instruction with ready_i tied high. Latency from REQ to valid_o is 2 cycles.
- Redirect (redirect_i=1) has the highest priority in any state, including over ready_i in HOLD. valid_o drops the next cycle. pc<=redirect_pc_i.
  - If redirect_pc_i[1:0]==0: next state is REQ.
  - Otherwise: next state is FAULT and misaligned_o<=1.
- A redirect in REQ leaves its read issued. Its response arrives while back in REQ and is ignored. A redirect in WAIT discards the capture.
- FAULT: mem_rd_en_o=0, valid_o=0, misaligned_o=1. Stays in FAULT until reset or an aligned redirect, which clears misaligned_o and goes to REQ. A misaligned redirect while in FAULT stays in FAULT and updates pc.
- Arithmetic: pc+4 wraps modulo 2^ADDR_W (32'hFFFF_FFFC -> 32'h0000_0000), with no flag.
- Outside HOLD: pc_o shows the current pc and instr_o holds its last value; the decoder qualifies on valid_o.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: adds outputs fetch_cnt_o[31:0] and stall_cnt_o[31:0], both reset to 0.
  - fetch_cnt_o increments on each HOLD&&ready_i&&!redirect_i.
  - stall_cnt_o increments on each cycle with valid_o&&!ready_i.
  - Both wrap at 2^32.
- Undefined: these ports and counters do not exist. Core behaviour is identical.

Decomposition:
- Shared package riscv_pkg (alongside t_risc_v_op and t_alu):
  - fetch_state_t enum {REQ, WAIT, HOLD, FAULT}
  - INSTR_NOP = 32'h0000_0013
  - INSTR_BYTES = 4
- Sub-module fetch_perf_cnt holds the two counters and is instantiated only under FETCH_PERF_CNT_EN. The FSM and PC stay in fetch_unit.

Test Plan:
- Reset then release, ready_i=1, memory holds word k at addr 4k: mem_addr_o sequence 0,4,8 with rd_en every 3rd cycle. valid_o high 2 cycles after each request, instr_o/pc_o = (mem[0],0), (mem[4],4), (mem[8],8).
- Backpressure: ready_i=0 for 5 cycles in HOLD at pc=8. instr_o/pc_o stay stable and no new mem_rd_en_o. On ready_i=1, next request at 12. With FETCH_PERF_CNT_EN, stall_cnt_o=5.
- Redirect in each of REQ/WAIT/HOLD to 32'h100, with ready_i=1 in HOLD: next request at 32'h100. Old/in-flight word is never presented and pc 4 is never fetched.
- Misaligned redirect to 32'h102: FAULT, misaligned_o=1, no reads. A later redirect to 32'h200 clears misaligned_o and fetches 32'h200.
- Wrap: RESET_PC=32'hFFFF_FFFC, accept one instruction. Next mem_addr_o=32'h0000_0000.
- Reset asserted during WAIT: next cycle valid_o=0, pc_o=RESET_PC, and a fresh request is issued after release.

Source files
------------

// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the RV32 core front end and datapath.
//   t_risc_v_op   : major opcode field (instr[6:0]) encodings
//   t_alu         : ALU operation selector used by decode/execute
//   fetch_state_t : fetch unit sequencer states
//   INSTR_NOP     : canonical NOP (addi x0, x0, 0), shown before the first fetch
//   INSTR_BYTES   : size of one instruction word in bytes (PC increment)
// -----------------------------------------------------------------------------
package riscv_pkg;

    typedef enum logic [6:0] {
        OP_LOAD   = 7'b0000011,
        OP_IMM    = 7'b0010011,
        OP_AUIPC  = 7'b0010111,
        OP_STORE  = 7'b0100011,
        OP_REG    = 7'b0110011,
        OP_LUI    = 7'b0110111,
        OP_BRANCH = 7'b1100011,
        OP_JALR   = 7'b1100111,
        OP_JAL    = 7'b1101111,
        OP_SYSTEM = 7'b1110011
    } t_risc_v_op;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND
    } t_alu;

    typedef enum logic [1:0] {
        REQ,
        WAIT,
        HOLD,
        FAULT
    } fetch_state_t;

    localparam logic [31:0] INSTR_NOP   = 32'h0000_0013;
    localparam int          INSTR_BYTES = 4;

    // A fetch target is usable only when it sits on a word boundary.
    function automatic logic word_aligned(input logic [1:0] lsb);
        return (lsb == 2'b00);
    endfunction

endpackage

// File: rtl/fetch_perf_cnt.sv
// -----------------------------------------------------------------------------
// fetch_perf_cnt
// Free-running performance counters for the fetch stage. Both counters are
// cleared by reset and wrap silently at 2^32.
//   clk_i        : clock
//   rst_i        : synchronous active-high reset
//   accept_i     : an instruction was handed to the decoder this cycle
//   stall_i      : an instruction was offered but the decoder held it off
//   fetch_cnt_o  : number of instructions accepted by the decoder
//   stall_cnt_o  : number of cycles the decoder applied backpressure
// -----------------------------------------------------------------------------
module fetch_perf_cnt (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        accept_i,
    input  logic        stall_i,
    output logic [31:0] fetch_cnt_o,
    output logic [31:0] stall_cnt_o
);

    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (accept_i) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            if (stall_i) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end

    assign fetch_cnt_o = fetch_cnt;
    assign stall_cnt_o = stall_cnt;

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage feeding the decoder. Keeps the PC, issues one read
// per instruction to a synchronous (one-cycle latency) instruction memory,
// captures the returned word and offers it to the decoder with valid/ready.
// Control may redirect the PC at any time; a target that is not word aligned
// parks the unit in a fault state until an aligned redirect or reset.
//
// Sequence per instruction: REQ (read strobe) -> WAIT (capture) -> HOLD
// (offer until accepted), i.e. 3 cycles per instruction at full rate.
//
// Ports:
//   clk_i          : clock, all state updates on the rising edge
//   rst_i          : synchronous active-high reset
//   mem_rd_en_o    : memory read strobe, one cycle per request
//   mem_addr_o     : byte address of the request (same as pc_o)
//   mem_data_i     : read data, valid the cycle after mem_rd_en_o
//   instr_o        : captured instruction for the decoder
//   pc_o           : PC of instr_o / of the current request
//   valid_o        : instr_o/pc_o are valid for the decoder
//   ready_i        : decoder accepts instr_o this cycle
//   redirect_i     : control requests a PC change (highest priority)
//   redirect_pc_i  : new PC target
//   misaligned_o   : last redirect target had bits [1:0] != 0
//   fetch_cnt_o    : accepted instruction count   (FETCH_PERF_CNT_EN only)
//   stall_cnt_o    : decoder backpressure cycles  (FETCH_PERF_CNT_EN only)
//
// Build option: define FETCH_PERF_CNT_EN to add the performance counters.
// -----------------------------------------------------------------------------
module fetch_unit
    import riscv_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    output logic              mem_rd_en_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [31:0]       mem_data_i,
    output logic [31:0]       instr_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic              valid_o,
    input  logic              ready_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic              misaligned_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       fetch_cnt_o,
    output logic [31:0]       stall_cnt_o
`endif
);

    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(INSTR_BYTES);

    fetch_state_t      state;
    fetch_state_t      state_nxt;
    logic [ADDR_W-1:0] pc_p0;
    logic [ADDR_W-1:0] pc_nxt;
    logic [31:0]       instr_p1;
    logic [31:0]       instr_nxt;
    logic              mis;
    logic              mis_nxt;
    logic              vld_p1;

    // ---- state register: PC (request stage) and captured word (capture stage)
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= REQ;
            pc_p0    <= RESET_PC;
            instr_p1 <= INSTR_NOP;
            mis      <= 1'b0;
        end else begin
            state    <= state_nxt;
            pc_p0    <= pc_nxt;
            instr_p1 <= instr_nxt;
            mis      <= mis_nxt;
        end
    end

    // ---- next-state logic
    // A redirect wins over everything, including a decoder accept in HOLD.
    // A read issued in REQ that is overtaken by a redirect still returns data
    // one cycle later, but we are back in REQ then and never capture it; only
    // WAIT samples mem_data_i, so stale responses cannot leak through.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_p0;
        instr_nxt = instr_p1;
        mis_nxt   = mis;

        if (redirect_i) begin
            pc_nxt = redirect_pc_i;
            if (word_aligned(redirect_pc_i[1:0])) begin
                state_nxt = REQ;
                mis_nxt   = 1'b0;
            end else begin
                state_nxt = FAULT;
                mis_nxt   = 1'b1;
            end
        end else begin
            unique case (state)
                REQ: begin
                    state_nxt = WAIT;
                end
                WAIT: begin
                    instr_nxt = mem_data_i;
                    state_nxt = HOLD;
                end
                HOLD: begin
                    if (ready_i) begin
                        // wraps modulo 2^ADDR_W by construction
                        pc_nxt    = pc_p0 + PC_STEP;
                        state_nxt = REQ;
                    end
                end
                FAULT: begin
                    state_nxt = FAULT;
                end
                default: begin
                    state_nxt = REQ;
                end
            endcase
        end
    end

    // ---- decoder-facing outputs
    assign vld_p1       = (state == HOLD);
    assign valid_o      = vld_p1;
    assign instr_o      = instr_p1;
    assign pc_o         = pc_p0;
    assign misaligned_o = mis;

    // Reset suppresses the strobe immediately so no read escapes while the
    // sequencer is being re-initialised.
    assign mem_rd_en_o  = (state == REQ) && !rst_i;
    assign mem_addr_o   = pc_p0;

`ifdef FETCH_PERF_CNT_EN
    logic accept;
    logic stall;

    assign accept = (state == HOLD) && ready_i && !redirect_i;
    assign stall  = vld_p1 && !ready_i;

    fetch_perf_cnt u_perf (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .accept_i    (accept),
        .stall_i     (stall),
        .fetch_cnt_o (fetch_cnt_o),
        .stall_cnt_o (stall_cnt_o)
    );
`endif

    // The fault flag and the FAULT state always move together, and a faulted
    // unit must never touch memory or offer an instruction.
    a_fault_flag: assert property (@(posedge clk_i) disable iff (rst_i)
        (state == FAULT) == mis);
    a_fault_quiet: assert property (@(posedge clk_i) disable iff (rst_i)
        mis |-> (!mem_rd_en_o && !valid_o));

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Scoreboard bench for fetch_unit. The reference model is the architectural
// instruction stream: starting at a PC, the decoder must receive consecutive
// words (PC, PC+4, ...) until a redirect restarts the stream at the target;
// a misaligned target yields no instructions at all. Stimulus pushes the
// expected (pc, word) stream into a queue; a negedge monitor pops on every
// decoder handshake. A second instance checks PC wrap from the top of memory.
// -----------------------------------------------------------------------------
module tb_fetch_unit;
    import riscv_pkg::*;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        mem_rd_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
    logic        misaligned;

    logic        ready2;
    logic        redirect2;
    logic [31:0] redirect_pc2;
    logic        mem_rd_en2;
    logic [31:0] mem_addr2;
    logic [31:0] mem_data2;
    logic [31:0] instr2;
    logic [31:0] pc2;
    logic        valid2;
    logic        misaligned2;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;
    logic [31:0] fetch_cnt2;
    logic [31:0] stall_cnt2;
`endif

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];
    logic mis_model;
    logic hold_prev;
    logic [31:0] prev_pc;
    logic [31:0] prev_instr;

    fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .mem_rd_en_o   (mem_rd_en),
        .mem_addr_o    (mem_addr),
        .mem_data_i    (mem_data),
        .instr_o       (instr),
        .pc_o          (pc),
        .valid_o       (valid),
        .ready_i       (ready),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .misaligned_o  (misaligned)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_cnt_o   (fetch_cnt),
        .stall_cnt_o   (stall_cnt)
`endif
    );

    fetch_unit #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk_i         (clk),
        .rst_i         (rst),
        .mem_rd_en_o   (mem_rd_en2),
        .mem_addr_o    (mem_addr2),
        .mem_data_i    (mem_data2),
        .instr_o       (instr2),
        .pc_o          (pc2),
        .valid_o       (valid2),
        .ready_i       (ready2),
        .redirect_i    (redirect2),
        .redirect_pc_i (redirect_pc2),
        .misaligned_o  (misaligned2)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_cnt_o   (fetch_cnt2),
        .stall_cnt_o   (stall_cnt2)
`endif
    );

    // Memory image: word k lives at byte address 4k, tagged so it is unique.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a >> 2) ^ 32'hC0DE_0000;
    endfunction

    // Synchronous memories: data appears the cycle after the strobe.
    always @(posedge clk) begin
        mem_data  <= mem_rd_en  ? mem_word(mem_addr)  : 32'hBAD0_BAD0;
        mem_data2 <= mem_rd_en2 ? mem_word(mem_addr2) : 32'hBAD0_BAD0;
    end

    // Architectural fault flag: set by a misaligned redirect, cleared by an
    // aligned one or by reset.
    always @(posedge clk) begin
        if (rst)           mis_model <= 1'b0;
        else if (redirect) mis_model <= (redirect_pc[1:0] != 2'b00);
    end

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_stream(input logic [31:0] start, input int n);
        logic [31:0] a;
        for (int i = 0; i < n; i++) begin
            a = start + 32'(4 * i);
            exp_q.push_back({a, mem_word(a)});
        end
    endtask

    // Advance until the next read strobe (bounded); report cycles taken.
    task automatic wait_req(input string name, input logic [31:0] exp_addr, output int cnt);
        cnt = 0;
        do begin
            cyc();
            cnt++;
        end while (!mem_rd_en && cnt < 20);
        if (!mem_rd_en) begin
            checks++;
            failures++;
            $display("FAIL %s: no read request within %0d cycles, required addr %h", name, cnt, exp_addr);
        end else begin
            chk32(name, mem_addr, exp_addr);
        end
    endtask

    // Redirect during the current cycle; the stream restarts at the target.
    task automatic redirect_to(input logic [31:0] t, input int n, input bit check);
        redirect    = 1'b1;
        redirect_pc = t;
        exp_q.delete();
        if (t[1:0] == 2'b00) push_stream(t, n);
        cyc();
        redirect = 1'b0;
        if (check) begin
            chk1 ("redir_valid_drop", valid, 1'b0);
            chk32("redir_pc", pc, t);
            chk1 ("redir_misaligned", misaligned, t[1:0] != 2'b00);
            chk1 ("redir_rd_en", mem_rd_en, t[1:0] == 2'b00);
        end
    endtask

    // Monitor: handshake scoreboard, hold stability and fault behaviour.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            chk1("misaligned", misaligned, mis_model);
            if (mis_model) begin
                chk1("fault_no_read", mem_rd_en, 1'b0);
                chk1("fault_no_valid", valid, 1'b0);
            end
            if (hold_prev) begin
                chk1 ("hold_valid", valid, 1'b1);
                chk32("hold_pc", pc, prev_pc);
                chk32("hold_instr", instr, prev_instr);
            end
            if (valid && ready && !redirect) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_accept: got pc %h instr %h, required no delivery", pc, instr);
                end else begin
                    e = exp_q.pop_front();
                    chk32("accept_pc", pc, e.pc);
                    chk32("accept_instr", instr, e.word);
                end
            end
        end
        hold_prev  <= !rst && valid && !ready && !redirect;
        prev_pc    <= pc;
        prev_instr <= instr;
    end

    task automatic wrap_check();
        int n;
        #1;
        chk1 ("wrap_rd_en", mem_rd_en2, 1'b1);
        chk32("wrap_first_addr", mem_addr2, 32'hFFFF_FFFC);
        n = 0;
        while (!valid2 && n < 10) begin
            cyc();
            n++;
        end
        chk1 ("wrap_valid", valid2, 1'b1);
        chk32("wrap_pc", pc2, 32'hFFFF_FFFC);
        chk32("wrap_instr", instr2, mem_word(32'hFFFF_FFFC));
        cyc();
        chk1 ("wrap_next_rd_en", mem_rd_en2, 1'b1);
        chk32("wrap_next_addr", mem_addr2, 32'h0000_0000);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] t;
        int          cnt;
        int          n;
        int          k;
        bit          early;

        rst          = 1'b1;
        ready        = 1'b1;
        redirect     = 1'b0;
        redirect_pc  = 32'h0;
        ready2       = 1'b1;
        redirect2    = 1'b0;
        redirect_pc2 = 32'h0;
        hold_prev    = 1'b0;

        repeat (3) cyc();
        chk1 ("rst_rd_en", mem_rd_en, 1'b0);
        chk1 ("rst_valid", valid, 1'b0);
        chk32("rst_pc", pc, 32'h0);
        chk32("rst_instr", instr, INSTR_NOP);
        chk1 ("rst_misaligned", misaligned, 1'b0);
        chk32("rst_pc_wrap", pc2, 32'hFFFF_FFFC);
        chk1 ("rst_rd_en_wrap", mem_rd_en2, 1'b0);

        // Release: straight-line fetch of 0, 4, 8 then backpressure at 8.
        rst = 1'b0;
        push_stream(32'h0, 4);
        fork
            begin
                #1;
                chk1 ("first_rd_en", mem_rd_en, 1'b1);
                chk32("first_addr", mem_addr, 32'h0);
                cyc();
                chk1("wait_valid", valid, 1'b0);
                chk1("wait_rd_en", mem_rd_en, 1'b0);
                cyc();
                chk1 ("latency_valid", valid, 1'b1);
                chk32("latency_pc", pc, 32'h0);
                wait_req("req_4", 32'h4, cnt);
                chk32("gap_4", 32'(cnt), 32'd1);
                wait_req("req_8", 32'h8, cnt);
                chk32("throughput_gap", 32'(cnt), 32'd3);
                ready = 1'b0;
                cyc();
                cyc();
                for (int i = 0; i < 5; i++) begin
                    chk1 ("bp_valid", valid, 1'b1);
                    chk32("bp_pc", pc, 32'h8);
                    chk32("bp_instr", instr, mem_word(32'h8));
                    chk1 ("bp_no_read", mem_rd_en, 1'b0);
                    if (i < 4) cyc();
                end
                cyc();
                ready = 1'b1;
                wait_req("req_12", 32'hC, cnt);
`ifdef FETCH_PERF_CNT_EN
                chk32("stall_cnt", stall_cnt, 32'd5);
                chk32("fetch_cnt", fetch_cnt, 32'd3);
`endif
            end
            wrap_check();
        join

        // Redirect in REQ (at pc 12), in WAIT and in HOLD.
        redirect_to(32'h100, 8, 1'b1);
        cyc();
        redirect_to(32'h200, 8, 1'b1);
        cyc();
        cyc();
        chk1 ("hold_before_redirect", valid, 1'b1);
        chk32("hold_pc_before_redirect", pc, 32'h200);
        redirect_to(32'h300, 8, 1'b1);

        // Misaligned target, misaligned update while faulted, then recovery.
        redirect_to(32'h102, 0, 1'b1);
        repeat (3) cyc();
        redirect_to(32'h106, 0, 1'b1);
        cyc();
        redirect_to(32'h200, 8, 1'b1);

        // Reset while a response is in flight.
        cyc();
        rst = 1'b1;
        exp_q.delete();
        cyc();
        chk1 ("midrst_rd_en", mem_rd_en, 1'b0);
        chk1 ("midrst_valid", valid, 1'b0);
        chk32("midrst_pc", pc, 32'h0);
        chk32("midrst_instr", instr, INSTR_NOP);
        chk1 ("midrst_misaligned", misaligned, 1'b0);
        rst = 1'b0;
        push_stream(32'h0, 8);
        #1;
        chk1 ("post_rst_rd_en", mem_rd_en, 1'b1);
        chk32("post_rst_addr", mem_addr, 32'h0);

        // Randomised segments: random targets, random backpressure, random
        // early redirects that abandon whatever is in flight.
        for (int s = 0; s < 40; s++) begin
            t = $urandom();
            if ($urandom_range(0, 7) == 0) t = 32'hFFFF_FFF4;
            if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
            else                           t[1:0] = 2'($urandom_range(1, 3));
            n = $urandom_range(1, 4);
            redirect_to(t, n, 1'b1);
            if (t[1:0] != 2'b00) begin
                repeat (4) begin
                    ready = 1'($urandom_range(0, 1));
                    cyc();
                end
                continue;
            end
            k     = 0;
            early = 1'b0;
            while (exp_q.size() != 0 && k < 100) begin
                ready = ($urandom_range(0, 2) != 0);
                if ($urandom_range(0, 59) == 0) begin
                    early = 1'b1;
                    break;
                end
                cyc();
                k++;
            end
            if (!early) begin
                checks++;
                if (exp_q.size() != 0) begin
                    failures++;
                    $display("FAIL seg_drain: %0d instructions still pending after %0d cycles, required 0", exp_q.size(), k);
                end
            end
        end

        redirect_to(32'h400, 0, 1'b0);
        ready = 1'b0;
        repeat (2) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
